wall_probe: RTL and testbench

- Collision stage directly upstream of the sprite motion block.
- Once per frame, samples the sprite position, size and current direction flags (L/R/U/D), then reads the maze wall-map ROM at the two leading-edge corner pixels of the sprite's next 1-px step.
- On a wall hit, asserts the opposite-direction bounce request (bnceL/R/U/D) for a fixed number of frames; the motion block consumes these.

---
 rtl/wall_probe.sv | 216 +++++++++++++++++++++
 tb/tb_wall_probe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_probe.sv
// wall_probe: once per frame, probes the two leading-edge corner tiles of the sprite's
// next 1-px step and holds an opposite-direction bounce request for a fixed number of frames.
module wall_probe #(
  parameter int TILE_SHIFT    = 4,
  parameter int MAP_W         = 40,
  parameter int MAP_H         = 30,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int BOUNCE_FRAMES = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  sprite_xpos,
  input  logic [9:0]  sprite_ypos,
  input  logic [9:0]  sprite_W,
  input  logic [9:0]  sprite_H,
  input  logic        L,
  input  logic        R,
  input  logic        U,
  input  logic        D,
  output logic [10:0] map_addr,
  input  logic        map_rd_data,
  output logic        bnceL,
  output logic        bnceR,
  output logic        bnceU,
  output logic        bnceD,
  output logic        wall_hit,
  output logic        busy
);
  localparam int               CNT_W    = $clog2(BOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [10:0]      SCR_W    = 11'(SCREEN_W);
  localparam logic [10:0]      SCR_H    = 11'(SCREEN_H);
  localparam logic [10:0]      TILES_W  = 11'(MAP_W);
  localparam logic [10:0]      TILES_H  = 11'(MAP_H);

  typedef enum logic [2:0] {IDLE = 3'd0, P0 = 3'd1, P1 = 3'd2, P2 = 3'd3, DECIDE = 3'd4} state_t;
  typedef enum logic [1:0] {DIR_L = 2'd0, DIR_R = 2'd1, DIR_U = 2'd2, DIR_D = 2'd3} dir_t;

  function automatic logic [10:0] tile_addr(input logic [10:0] px, input logic [10:0] py);
    logic [21:0] a;
    a = 22'(py >> TILE_SHIFT) * 22'(MAP_W) + 22'(px >> TILE_SHIFT);
    return a[10:0];
  endfunction

  // Negative coordinates wrap to large 11-bit values, so one unsigned bound covers both sides.
  function automatic logic off_screen(input logic [10:0] px, input logic [10:0] py);
    return (px >= SCR_W) || (py >= SCR_H) ||
           ((px >> TILE_SHIFT) >= TILES_W) || ((py >> TILE_SHIFT) >= TILES_H);
  endfunction

  state_t           state_r, state_nxt_s;
  dir_t             dir_s, dir_r;
  logic             dir_valid_s;
  logic             frame_clk_delayed_r, frame_edge_r;
  logic [10:0]      x_s, y_s, w_s, h_s;
  logic [10:0]      pt0_x_s, pt0_y_s, pt1_x_s, pt1_y_s;
  logic [10:0]      pt1_x_r, pt1_y_r;
  logic             off0_r, off1_r, hit0_r, hit1_r;
  logic             decide_hit_s;
  logic [CNT_W-1:0] bounce_cnt_r;

  assign x_s = {1'b0, sprite_xpos};
  assign y_s = {1'b0, sprite_ypos};
  assign w_s = {1'b0, sprite_W};
  assign h_s = {1'b0, sprite_H};
  assign decide_hit_s = (state_r == DECIDE) && (hit0_r || hit1_r);

  // Rising-edge detect of the frame strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_delayed_r <= 1'b0;
      frame_edge_r        <= 1'b0;
    end else begin
      frame_clk_delayed_r <= frame_clk;
      frame_edge_r        <= frame_clk & ~frame_clk_delayed_r;
    end
  end

  // Direction priority L > R > U > D and the two probe points for that direction.
  always_comb begin
    dir_s       = DIR_L;
    dir_valid_s = 1'b1;
    if (L) begin
      dir_s = DIR_L;
    end else if (R) begin
      dir_s = DIR_R;
    end else if (U) begin
      dir_s = DIR_U;
    end else if (D) begin
      dir_s = DIR_D;
    end else begin
      dir_valid_s = 1'b0;
    end
    pt0_x_s = x_s;
    pt0_y_s = y_s;
    pt1_x_s = x_s;
    pt1_y_s = y_s;
    case (dir_s)
      DIR_L: begin
        pt0_x_s = x_s - 11'd1;        pt0_y_s = y_s;
        pt1_x_s = x_s - 11'd1;        pt1_y_s = y_s + h_s;
      end
      DIR_R: begin
        pt0_x_s = x_s + w_s + 11'd1;  pt0_y_s = y_s;
        pt1_x_s = x_s + w_s + 11'd1;  pt1_y_s = y_s + h_s;
      end
      DIR_U: begin
        pt0_x_s = x_s;                pt0_y_s = y_s - 11'd1;
        pt1_x_s = x_s + w_s;          pt1_y_s = y_s - 11'd1;
      end
      DIR_D: begin
        pt0_x_s = x_s;                pt0_y_s = y_s + h_s + 11'd1;
        pt1_x_s = x_s + w_s;          pt1_y_s = y_s + h_s + 11'd1;
      end
      default: begin
        pt0_x_s = x_s;
        pt0_y_s = y_s;
      end
    endcase
  end

  // Probe sequencer next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_edge_r && dir_valid_s) begin
          state_nxt_s = P0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      P0:      state_nxt_s = P1;
      P1:      state_nxt_s = P2;
      P2:      state_nxt_s = DECIDE;
      DECIDE:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and busy flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
    end
  end

  // Probe datapath: the first address is issued straight from the frame-edge cycle so the
  // ROM data lines up with P1 and P2.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dir_r    <= DIR_L;
      pt1_x_r  <= 11'd0;
      pt1_y_r  <= 11'd0;
      off0_r   <= 1'b0;
      off1_r   <= 1'b0;
      hit0_r   <= 1'b0;
      hit1_r   <= 1'b0;
      map_addr <= 11'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_edge_r && dir_valid_s) begin
            dir_r    <= dir_s;
            pt1_x_r  <= pt1_x_s;
            pt1_y_r  <= pt1_y_s;
            off0_r   <= off_screen(pt0_x_s, pt0_y_s);
            off1_r   <= off_screen(pt1_x_s, pt1_y_s);
            map_addr <= tile_addr(pt0_x_s, pt0_y_s);
          end
        end
        P0:      map_addr <= tile_addr(pt1_x_r, pt1_y_r);
        P1:      hit0_r   <= map_rd_data | off0_r;
        P2:      hit1_r   <= map_rd_data | off1_r;
        default: hit0_r   <= hit0_r;
      endcase
    end
  end

  // Bounce hold: a fresh hit reloads the counter even on a frame-edge cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bounce_cnt_r <= CNT_ZERO;
      bnceL        <= 1'b0;
      bnceR        <= 1'b0;
      bnceU        <= 1'b0;
      bnceD        <= 1'b0;
      wall_hit     <= 1'b0;
    end else begin
      wall_hit <= decide_hit_s;
      if (decide_hit_s) begin
        bounce_cnt_r <= CNT_LOAD;
        bnceL        <= (dir_r == DIR_R);
        bnceR        <= (dir_r == DIR_L);
        bnceU        <= (dir_r == DIR_D);
        bnceD        <= (dir_r == DIR_U);
      end else if (frame_edge_r && (bounce_cnt_r != CNT_ZERO)) begin
        bounce_cnt_r <= bounce_cnt_r - CNT_ONE;
        if (bounce_cnt_r == CNT_ONE) begin
          bnceL <= 1'b0;
          bnceR <= 1'b0;
          bnceU <= 1'b0;
          bnceD <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_wall_probe.sv
// Bench for wall_probe: directed scenarios plus randomized frames checked against an
// event-level model built from probe geometry, tile lookup and bounce-hold rules.
module tb_wall_probe;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int MAP_W    = 40;
  localparam int TILE     = 16;
  localparam int BF       = 8;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, L, R, U, D, map_rd_data;
  logic [9:0]  sprite_xpos, sprite_ypos, sprite_W, sprite_H;
  logic [10:0] map_addr;
  logic        bnceL, bnceR, bnceU, bnceD, wall_hit, busy;
  logic        wall_map [0:2047];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  // Model state: probe start cycle, pending hit cycle, bounce hold, expected address.
  int m_start = -100, m_hit_cyc = -1, m_edge_cyc = -1, m_cnt = 0, m_addr = 0, m_a1 = -1;
  logic [3:0] m_bnce = 4'b0000, m_pend = 4'b0000;
  bit m_wall_hit = 1'b0;

  wall_probe dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .sprite_xpos(sprite_xpos), .sprite_ypos(sprite_ypos),
    .sprite_W(sprite_W), .sprite_H(sprite_H),
    .L(L), .R(R), .U(U), .D(D),
    .map_addr(map_addr), .map_rd_data(map_rd_data),
    .bnceL(bnceL), .bnceR(bnceR), .bnceU(bnceU), .bnceD(bnceD),
    .wall_hit(wall_hit), .busy(busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) map_rd_data <= wall_map[map_addr];

  function automatic void probe_model(output bit valid, output bit hit, output logic [3:0] bn,
                                      output int a0, output int a1);
    int x, y, w, h, addr;
    int px [2];
    int py [2];
    x = sprite_xpos; y = sprite_ypos; w = sprite_W; h = sprite_H;
    valid = 1'b1; hit = 1'b0; bn = 4'b0000; a0 = -1; a1 = -1;
    if (L) begin
      px[0] = x - 1; px[1] = x - 1; py[0] = y; py[1] = y + h; bn = 4'b0100;
    end else if (R) begin
      px[0] = x + w + 1; px[1] = x + w + 1; py[0] = y; py[1] = y + h; bn = 4'b1000;
    end else if (U) begin
      px[0] = x; px[1] = x + w; py[0] = y - 1; py[1] = y - 1; bn = 4'b0001;
    end else if (D) begin
      px[0] = x; px[1] = x + w; py[0] = y + h + 1; py[1] = y + h + 1; bn = 4'b0010;
    end else begin
      valid = 1'b0; px[0] = 0; px[1] = 0; py[0] = 0; py[1] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (px[i] < 0 || px[i] >= SCREEN_W || py[i] < 0 || py[i] >= SCREEN_H) begin
        hit = 1'b1;
      end else begin
        addr = (py[i] / TILE) * MAP_W + px[i] / TILE;
        if (wall_map[addr]) hit = 1'b1;
        if (i == 0) a0 = addr; else a1 = addr;
      end
    end
  endfunction

  // Advance one clock and apply the model's view of what the DUT did on that edge.
  task automatic step();
    bit vld, hit;
    logic [3:0] bn;
    int a0, a1;
    @(posedge Clk);
    cyc++;
    m_wall_hit = 1'b0;
    if (Reset) begin
      m_start = -100; m_hit_cyc = -1; m_edge_cyc = -1; m_cnt = 0; m_bnce = 4'b0000; m_addr = 0;
    end else begin
      if (cyc == m_hit_cyc) begin
        m_bnce = m_pend; m_cnt = BF; m_wall_hit = 1'b1;
      end else if (cyc == m_edge_cyc && m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_bnce = 4'b0000;
      end
      if (cyc == m_start + 1) m_addr = m_a1;
      if (cyc == m_edge_cyc && !(cyc >= m_start && cyc <= m_start + 4)) begin
        probe_model(vld, hit, bn, a0, a1);
        if (vld) begin
          m_start = cyc; m_addr = a0; m_a1 = a1; m_pend = bn;
          m_hit_cyc = hit ? cyc + 4 : -1;
        end
      end
    end
    #1;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1; m_edge_cyc = cyc + 2; step();
    frame_clk = 1'b0; step();
  endtask

  task automatic set_sprite(input int x, input int y, input int w, input int h, input logic [3:0] d);
    sprite_xpos = 10'(x); sprite_ypos = 10'(y); sprite_W = 10'(w); sprite_H = 10'(h);
    {L, R, U, D} = d;
  endtask

  task automatic clear_map();
    for (int i = 0; i < 2048; i++) wall_map[i] = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0;
    set_sprite(0, 0, 0, 0, 4'b0000);
    repeat (3) step();
    vectors++;
    if ({busy, wall_hit, bnceL, bnceR, bnceU, bnceD} !== 6'b0) begin
      miscompares++; $display("FAIL reset_outputs: got %b expected 000000",
                              {busy, wall_hit, bnceL, bnceR, bnceU, bnceD});
    end
    vectors++;
    if (map_addr !== 11'd0) begin
      miscompares++; $display("FAIL reset_addr: got %0d expected 0", map_addr);
    end
    Reset = 1'b0;
    repeat (4) begin
      frame_pulse();
      repeat (3) begin
        step();
        vectors++;
        if ({busy, wall_hit, bnceL, bnceR, bnceU, bnceD} !== 6'b0 || map_addr !== 11'd0) begin
          miscompares++; $display("FAIL idle_no_flags: got outs=%b addr=%0d expected 0/0",
                                  {busy, wall_hit, bnceL, bnceR, bnceU, bnceD}, map_addr);
        end
      end
    end
  endtask

  task automatic test_wall_right();
    clear_map(); wall_map[102] = 1'b1;
    set_sprite(331, 33, 20, 20, 4'b0100);
    frame_pulse();
    vectors++;
    if (map_addr !== 11'd102 || busy !== 1'b1) begin
      miscompares++; $display("FAIL right_addr0: got addr=%0d busy=%b expected 102/1", map_addr, busy);
    end
    step();
    vectors++;
    if (map_addr !== 11'd142) begin
      miscompares++; $display("FAIL right_addr1: got %0d expected 142", map_addr);
    end
    set_sprite(331, 33, 20, 20, 4'b0000);
    repeat (2) step();
    vectors++;
    if (wall_hit !== 1'b0) begin
      miscompares++; $display("FAIL right_early_hit: got %b expected 0", wall_hit);
    end
    step();
    vectors++;
    if (wall_hit !== 1'b1 || {bnceL, bnceR, bnceU, bnceD} !== 4'b1000) begin
      miscompares++; $display("FAIL right_hit: got hit=%b bnce=%b expected 1/1000",
                              wall_hit, {bnceL, bnceR, bnceU, bnceD});
    end
    step();
    vectors++;
    if (wall_hit !== 1'b0) begin
      miscompares++; $display("FAIL right_pulse_len: got %b expected 0", wall_hit);
    end
    for (int i = 1; i <= BF; i++) begin
      frame_pulse();
      vectors++;
      if (bnceL !== ((i < BF) ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL right_hold_%0d: got bnceL=%b expected %b", i, bnceL, i < BF);
      end
    end
  endtask

  task automatic test_no_hit();
    clear_map();
    set_sprite(331, 33, 20, 20, 4'b0100);
    frame_pulse();
    set_sprite(331, 33, 20, 20, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      vectors++;
      if (busy !== (i < 4) || wall_hit !== 1'b0 || {bnceL, bnceR, bnceU, bnceD} !== 4'b0) begin
        miscompares++; $display("FAIL no_hit_%0d: got busy=%b hit=%b bnce=%b expected %b/0/0000",
                                i, busy, wall_hit, {bnceL, bnceR, bnceU, bnceD}, i < 4);
      end
    end
  endtask

  task automatic test_offscreen_left();
    clear_map();
    set_sprite(0, 100, 15, 15, 4'b1000);
    frame_pulse();
    set_sprite(0, 100, 15, 15, 4'b0000);
    repeat (4) step();
    vectors++;
    if (wall_hit !== 1'b1 || {bnceL, bnceR, bnceU, bnceD} !== 4'b0100) begin
      miscompares++; $display("FAIL offscreen_left: got hit=%b bnce=%b expected 1/0100",
                              wall_hit, {bnceL, bnceR, bnceU, bnceD});
    end
  endtask

  task automatic test_priority();
    clear_map();
    set_sprite(200, 0, 15, 15, 4'b0011);
    frame_pulse();
    set_sprite(200, 0, 15, 15, 4'b0000);
    repeat (4) step();
    vectors++;
    if (wall_hit !== 1'b1 || {bnceL, bnceR, bnceU, bnceD} !== 4'b0001) begin
      miscompares++; $display("FAIL priority_ud: got hit=%b bnce=%b expected 1/0001",
                              wall_hit, {bnceL, bnceR, bnceU, bnceD});
    end
  endtask

  task automatic test_back_to_back();
    clear_map(); wall_map[102] = 1'b1;
    set_sprite(331, 33, 20, 20, 4'b0100);
    frame_pulse();
    set_sprite(331, 33, 20, 20, 4'b0000);
    repeat (4) step();
    repeat (4) frame_pulse();
    // Probe down into the bottom screen edge while the L bounce has count 4.
    set_sprite(100, 460, 10, 19, 4'b0001);
    frame_pulse();
    vectors++;
    if ({bnceL, bnceR, bnceU, bnceD} !== 4'b1000) begin
      miscompares++; $display("FAIL reload_pre: got %b expected 1000", {bnceL, bnceR, bnceU, bnceD});
    end
    set_sprite(100, 460, 10, 19, 4'b0000);
    repeat (2) step();
    frame_clk = 1'b1; m_edge_cyc = cyc + 2;
    step();
    frame_clk = 1'b0;
    step();
    vectors++;
    if (wall_hit !== 1'b1 || {bnceL, bnceR, bnceU, bnceD} !== 4'b0010) begin
      miscompares++; $display("FAIL reload_hit: got hit=%b bnce=%b expected 1/0010",
                              wall_hit, {bnceL, bnceR, bnceU, bnceD});
    end
    for (int i = 1; i <= BF; i++) begin
      frame_pulse();
      vectors++;
      if (bnceU !== ((i < BF) ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL reload_hold_%0d: got bnceU=%b expected %b", i, bnceU, i < BF);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_map(); wall_map[102] = 1'b1;
    set_sprite(331, 33, 20, 20, 4'b0100);
    frame_pulse();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    set_sprite(331, 33, 20, 20, 4'b0000);
    vectors++;
    if (busy !== 1'b0 || map_addr !== 11'd0) begin
      miscompares++; $display("FAIL reset_mid: got busy=%b addr=%0d expected 0/0", busy, map_addr);
    end
    repeat (6) begin
      step();
      vectors++;
      if (wall_hit !== 1'b0 || busy !== 1'b0 || {bnceL, bnceR, bnceU, bnceD} !== 4'b0) begin
        miscompares++; $display("FAIL reset_mid_after: got hit=%b busy=%b bnce=%b expected 0/0/0000",
                                wall_hit, busy, {bnceL, bnceR, bnceU, bnceD});
      end
    end
  endtask

  task automatic test_random();
    int gap;
    logic [3:0] d;
    for (int i = 0; i < 2048; i++) wall_map[i] = ($urandom_range(0, 5) == 0);
    for (int f = 0; f < 120; f++) begin
      d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) d = 4'b0000;
      set_sprite($urandom_range(0, 660), $urandom_range(0, 500),
                 $urandom_range(0, 47), $urandom_range(0, 47), d);
      gap = $urandom_range(0, 7);
      for (int k = 0; k < gap + 2; k++) begin
        if (k == 0) begin
          frame_clk = 1'b1; m_edge_cyc = cyc + 2;
        end else begin
          frame_clk = 1'b0;
        end
        step();
        vectors++;
        if (busy !== ((cyc >= m_start) && (cyc <= m_start + 3)) || wall_hit !== m_wall_hit ||
            {bnceL, bnceR, bnceU, bnceD} !== m_bnce) begin
          miscompares++;
          $display("FAIL random_f%0d_c%0d: got busy=%b hit=%b bnce=%b expected busy=%b hit=%b bnce=%b",
                   f, cyc, busy, wall_hit, {bnceL, bnceR, bnceU, bnceD},
                   (cyc >= m_start) && (cyc <= m_start + 3), m_wall_hit, m_bnce);
        end
        if (m_addr >= 0) begin
          vectors++;
          if (map_addr !== 11'(m_addr)) begin
            miscompares++; $display("FAIL random_addr_c%0d: got %0d expected %0d", cyc, map_addr, m_addr);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wall_right();
    test_no_hit();
    test_offscreen_left();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
